cond_unit: RTL

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_unit_if.sv | 39 +++
 rtl/cond_eval.sv | 39 +++
 rtl/cond_unit.sv | 99 +++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition-code, flag-index and IT-state definitions for the condition unit.
package cond_pkg;

  localparam int unsigned FLAGS_W    = 4;
  localparam int unsigned COND_W     = 4;
  localparam int unsigned IT_STATE_W = 8;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] EQ = 4'h0;
  localparam logic [COND_W-1:0] NE = 4'h1;
  localparam logic [COND_W-1:0] CS = 4'h2;
  localparam logic [COND_W-1:0] CC = 4'h3;
  localparam logic [COND_W-1:0] MI = 4'h4;
  localparam logic [COND_W-1:0] PL = 4'h5;
  localparam logic [COND_W-1:0] VS = 4'h6;
  localparam logic [COND_W-1:0] VC = 4'h7;
  localparam logic [COND_W-1:0] HI = 4'h8;
  localparam logic [COND_W-1:0] LS = 4'h9;
  localparam logic [COND_W-1:0] GE = 4'hA;
  localparam logic [COND_W-1:0] LT = 4'hB;
  localparam logic [COND_W-1:0] GT = 4'hC;
  localparam logic [COND_W-1:0] LE = 4'hD;
  localparam logic [COND_W-1:0] AL = 4'hE;
  localparam logic [COND_W-1:0] NV = 4'hF;

  // Flag groups must split the 4-bit register evenly.
  function automatic logic legal_flag_groups(input int unsigned groups);
    return (groups == 1) || (groups == 2) || (groups == 4);
  endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Bus between the main control FSM (master) and the condition unit (slave).
interface cond_unit_if
  import cond_pkg::*;
#(
  parameter int unsigned FLAG_GROUPS = 2
);

  logic [COND_W-1:0]      Cond;
  logic [FLAGS_W-1:0]     ALUFlags;
  logic [FLAG_GROUPS-1:0] FlagW;
  logic                   PCS;
  logic                   NextPC;
  logic                   RegW;
  logic                   MemW;
  logic                   InstrStart;
  logic                   ITValid;
  logic [COND_W-1:0]      ITFirstCond;
  logic [3:0]             ITMask;

  logic                   PCWrite;
  logic                   RegWrite;
  logic                   MemWrite;
  logic [FLAGS_W-1:0]     Flags;
  logic                   CondExOut;
  logic                   ITActive;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
           InstrStart, ITValid, ITFirstCond, ITMask,
    input  PCWrite, RegWrite, MemWrite, Flags, CondExOut, ITActive
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
           InstrStart, ITValid, ITFirstCond, ITMask,
    output PCWrite, RegWrite, MemWrite, Flags, CondExOut, ITActive
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluation against the current {N,Z,C,V} flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex_c
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex_c = 1'b0;
    case (cond)
      EQ:      cond_ex_c = z;
      NE:      cond_ex_c = ~z;
      CS:      cond_ex_c = c;
      CC:      cond_ex_c = ~c;
      MI:      cond_ex_c = n;
      PL:      cond_ex_c = ~n;
      VS:      cond_ex_c = v;
      VC:      cond_ex_c = ~v;
      HI:      cond_ex_c = c & ~z;
      LS:      cond_ex_c = ~c | z;
      GE:      cond_ex_c = ~(n ^ v);
      LT:      cond_ex_c = n ^ v;
      GT:      cond_ex_c = ~z & ~(n ^ v);
      LE:      cond_ex_c = z | (n ^ v);
      AL:      cond_ex_c = 1'b1;
      default: cond_ex_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: flag register, latched condition result and write gating.
// IT-block support is compiled in only when COND_UNIT_IT_EN is defined.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned FLAG_GROUPS = 2
) (
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  localparam int unsigned GROUP_W = FLAGS_W / FLAG_GROUPS;

  if (!legal_flag_groups(FLAG_GROUPS)) begin : g_bad_groups
    $error("cond_unit: FLAG_GROUPS must be 1, 2 or 4");
  end

  logic [FLAGS_W-1:0] flags_q;
  logic [FLAGS_W-1:0] flags_nxt;
  logic               cond_ex_q;
  logic               cond_ex_c;
  logic [COND_W-1:0]  cond_sel;
  logic               it_active;

`ifdef COND_UNIT_IT_EN
  logic [IT_STATE_W-1:0] it_state_q;
  logic [IT_STATE_W-1:0] it_state_nxt;

  assign it_active = (it_state_q[3:0] != 4'b0);
  assign cond_sel  = it_active ? it_state_q[7:4] : bus.Cond;

  // A new IT load wins over slot advance; skipped slots still advance.
  always_comb begin
    it_state_nxt = it_state_q;
    if (bus.ITValid) begin
      if (bus.ITMask != 4'b0) begin
        it_state_nxt = {bus.ITFirstCond, bus.ITMask};
      end
    end else if (bus.InstrStart && it_active) begin
      if (it_state_q[2:0] == 3'b0) begin
        it_state_nxt = '0;
      end else begin
        it_state_nxt[4:0] = {it_state_q[3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      it_state_q <= '0;
    end else begin
      it_state_q <= it_state_nxt;
    end
  end
`else
  logic unused_it;

  assign unused_it = ^{bus.ITValid, bus.ITFirstCond, bus.ITMask};
  assign it_active = 1'b0;
  assign cond_sel  = bus.Cond;
`endif

  cond_eval u_cond_eval (
    .cond      (cond_sel),
    .flags     (flags_q),
    .cond_ex_c (cond_ex_c)
  );

  // Each enabled group takes its ALU slice only when the current instruction executes.
  always_comb begin
    flags_nxt = flags_q;
    for (int unsigned g = 0; g < FLAG_GROUPS; g++) begin
      if (bus.FlagW[g] && cond_ex_q) begin
        flags_nxt[g*GROUP_W +: GROUP_W] = bus.ALUFlags[g*GROUP_W +: GROUP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      if (bus.InstrStart) begin
        cond_ex_q <= cond_ex_c;
      end
    end
  end

  assign bus.RegWrite  = bus.RegW & cond_ex_q;
  assign bus.MemWrite  = bus.MemW & cond_ex_q;
  assign bus.PCWrite   = (bus.PCS | bus.NextPC) & cond_ex_q;
  assign bus.Flags     = flags_q;
  assign bus.CondExOut = cond_ex_q;
  assign bus.ITActive  = it_active;

endmodule
